// File: rtl/reaction_pkg.sv
// Shared definitions for the reaction-timer scoreboard.
//   state_t  : scoreboard FSM states
//   SEL_*    : encoding of the display select input
package reaction_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARMED,
    ST_TIMING,
    ST_RECORD,
    ST_SHOW
  } state_t;

  localparam logic [1:0] SEL_LAST  = 2'd0;
  localparam logic [1:0] SEL_BEST  = 2'd1;
  localparam logic [1:0] SEL_AVG   = 2'd2;
  localparam logic [1:0] SEL_COUNT = 2'd3;

endpackage

// File: rtl/score_history.sv
// Circular buffer of the last 2^HIST_LOG2 recorded times with a running sum.
//   clk, reset_n : clock, async active-low reset
//   i_wr         : one-cycle write pulse carrying a new recorded time
//   i_data       : time to record
//   i_clr        : synchronous wipe of history, sum and full flag
//   o_avg        : sum >> HIST_LOG2 once full, else 0
//   o_full       : window has been filled at least once since clear/reset
module score_history #(
  parameter int COUNT_BITS = 16,
  parameter int HIST_LOG2  = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  i_wr,
  input  logic [COUNT_BITS-1:0] i_data,
  input  logic                  i_clr,
  output logic [COUNT_BITS-1:0] o_avg,
  output logic                  o_full
);

  localparam int N  = 1 << HIST_LOG2;
  localparam int SW = COUNT_BITS + HIST_LOG2;

  logic [COUNT_BITS-1:0] r_mem [N];
  logic [HIST_LOG2-1:0]  r_ptr;
  logic [SW-1:0]         r_sum;
  logic                  r_full;
  logic [SW-1:0]         w_sum_nxt;

  // Empty slots hold 0, so subtracting the overwritten entry is always valid.
  assign w_sum_nxt = r_sum - {{HIST_LOG2{1'b0}}, r_mem[r_ptr]}
                           + {{HIST_LOG2{1'b0}}, i_data};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < N; i++) r_mem[i] <= '0;
      r_ptr  <= '0;
      r_sum  <= '0;
      r_full <= 1'b0;
    end else if (i_clr) begin
      for (int i = 0; i < N; i++) r_mem[i] <= '0;
      r_ptr  <= '0;
      r_sum  <= '0;
      r_full <= 1'b0;
    end else if (i_wr) begin
      r_mem[r_ptr] <= i_data;
      r_ptr        <= r_ptr + 1'b1;
      r_sum        <= w_sum_nxt;
      // Writing the last slot completes the first pass through the window.
      if (r_ptr == HIST_LOG2'(N - 1)) r_full <= 1'b1;
    end
  end

  assign o_full = r_full;
  assign o_avg  = r_full ? r_sum[SW-1:HIST_LOG2] : '0;

endmodule

// File: rtl/reaction_scoreboard.sv
// Reaction-timer scoreboard: tracks last/best/average times, attempts and
// false-start / no-response / new-best flags; drives a registered display mux.
// Optional feature macro: SCOREBOARD_AVG_EN (history window + average).
//   clk, reset_n   : clock, async active-low reset
//   arm            : pulse, lights sequence started
//   lights_out     : pulse, lights extinguished
//   stop           : level, reaction key held (synchronised)
//   clear          : pulse, wipe all statistics
//   count          : live ms count
//   sel            : display select (last/best/avg/attempts)
//   disp_value     : registered selected value
//   false_start, no_response, new_best, avg_valid : status flags
module reaction_scoreboard
  import reaction_pkg::*;
#(
  parameter int COUNT_BITS = 16,
  parameter int HIST_LOG2  = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  arm,
  input  logic                  lights_out,
  input  logic                  stop,
  input  logic                  clear,
  input  logic [COUNT_BITS-1:0] count,
  input  logic [1:0]            sel,
  output logic [COUNT_BITS-1:0] disp_value,
  output logic                  false_start,
  output logic                  no_response,
  output logic                  new_best,
  output logic                  avg_valid
);

  state_t r_state, w_state_nxt;

  logic                  r_stop_q;
  logic [COUNT_BITS-1:0] r_last, r_best, r_attempts, r_disp;
  logic                  r_false, r_nores, r_newbest;
  logic                  w_stop_edge, w_cnt_max, w_record;
  logic [COUNT_BITS-1:0] w_avg;
  logic                  w_full;

  assign w_stop_edge = stop & ~r_stop_q;
  assign w_cnt_max   = &count;
  assign w_record    = (r_state == ST_RECORD) && !clear;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= ST_IDLE;
      r_stop_q <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_stop_q <= stop;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (clear) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE, ST_SHOW: if (arm) w_state_nxt = ST_ARMED;
        // A press in the same cycle as lights_out is still a false start.
        ST_ARMED: begin
          if (w_stop_edge)     w_state_nxt = ST_SHOW;
          else if (lights_out) w_state_nxt = ST_TIMING;
        end
        ST_TIMING: begin
          if (w_stop_edge)    w_state_nxt = ST_RECORD;
          else if (w_cnt_max) w_state_nxt = ST_SHOW;
        end
        ST_RECORD: w_state_nxt = ST_SHOW;
        default:   w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_last     <= '0;
      r_best     <= '0;
      r_attempts <= '0;
      r_false    <= 1'b0;
      r_nores    <= 1'b0;
      r_newbest  <= 1'b0;
    end else if (clear) begin
      r_last     <= '0;
      r_best     <= '0;
      r_attempts <= '0;
      r_false    <= 1'b0;
      r_nores    <= 1'b0;
      r_newbest  <= 1'b0;
    end else begin
      if ((r_state == ST_IDLE || r_state == ST_SHOW) && arm) begin
        r_false   <= 1'b0;
        r_nores   <= 1'b0;
        r_newbest <= 1'b0;
      end
      if (r_state == ST_ARMED && w_stop_edge) r_false <= 1'b1;
      if (r_state == ST_TIMING && !w_stop_edge && w_cnt_max) r_nores <= 1'b1;
      if (w_record) begin
        r_last <= count;
        if (~&r_attempts) r_attempts <= r_attempts + 1'b1;
        // attempts==0 marks an empty best; ties do not count as a record.
        if (r_attempts == '0 || count < r_best) begin
          r_best    <= count;
          r_newbest <= 1'b1;
        end
      end
    end
  end

`ifdef SCOREBOARD_AVG_EN
  score_history #(
    .COUNT_BITS (COUNT_BITS),
    .HIST_LOG2  (HIST_LOG2)
  ) u_hist (
    .clk     (clk),
    .reset_n (reset_n),
    .i_wr    (w_record),
    .i_data  (count),
    .i_clr   (clear),
    .o_avg   (w_avg),
    .o_full  (w_full)
  );
`else
  assign w_avg  = '0;
  assign w_full = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_disp <= '0;
    end else begin
      case (sel)
        SEL_LAST:  r_disp <= r_last;
        SEL_BEST:  r_disp <= r_best;
        SEL_AVG:   r_disp <= w_avg;
        default:   r_disp <= r_attempts;
      endcase
    end
  end

  assign disp_value  = r_disp;
  assign false_start = r_false;
  assign no_response = r_nores;
  assign new_best    = r_newbest;
  assign avg_valid   = w_full;

endmodule

// File: tb/tb_reaction_scoreboard.sv
module tb_reaction_scoreboard;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        arm = 1'b0, lights_out = 1'b0, stop = 1'b0, clear = 1'b0;
  logic [15:0] count = '0;
  logic [1:0]  sel = 2'd0;
  logic [15:0] disp_value;
  logic        false_start, no_response, new_best, avg_valid;

  int n_cmp = 0;
  int n_bad = 0;

`ifdef SCOREBOARD_AVG_EN
  localparam bit AVG_ON = 1'b1;
`else
  localparam bit AVG_ON = 1'b0;
`endif

  reaction_scoreboard #(.COUNT_BITS(16), .HIST_LOG2(2)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .arm         (arm),
    .lights_out  (lights_out),
    .stop        (stop),
    .clear       (clear),
    .count       (count),
    .sel         (sel),
    .disp_value  (disp_value),
    .false_start (false_start),
    .no_response (no_response),
    .new_best    (new_best),
    .avg_valid   (avg_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic rd(input logic [1:0] s, input string tag, input logic [31:0] exp);
    @(negedge clk) sel = s;
    @(negedge clk) chk(tag, {16'd0, disp_value}, exp);
  endtask

  task automatic pulse_arm();
    @(negedge clk) arm = 1'b1;
    @(negedge clk) arm = 1'b0;
  endtask

  task automatic pulse_clear();
    @(negedge clk) clear = 1'b1;
    @(negedge clk) clear = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  // Full valid attempt: arm, lights out, press with count held at v.
  task automatic attempt(input logic [15:0] v);
    @(negedge clk) begin count = v; arm = 1'b1; end
    @(negedge clk) begin arm = 1'b0; lights_out = 1'b1; end
    @(negedge clk) begin lights_out = 1'b0; stop = 1'b1; end
    repeat (3) @(negedge clk);
    stop = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_disp", {16'd0, disp_value}, 0);
    chk("rst_fs", {31'd0, false_start}, 0);
    chk("rst_nr", {31'd0, no_response}, 0);
    chk("rst_nb", {31'd0, new_best}, 0);
    chk("rst_av", {31'd0, avg_valid}, 0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    attempt(16'd250);
    chk("a1_last", {16'd0, disp_value}, 250);
    rd(2'd1, "a1_best", 250);
    chk("a1_nb", {31'd0, new_best}, 1);
    rd(2'd3, "a1_att", 1);

    attempt(16'd300);
    rd(2'd1, "a2_best", 250);
    chk("a2_nb", {31'd0, new_best}, 0);
    rd(2'd0, "a2_last", 300);

    attempt(16'd180);
    rd(2'd1, "a3_best", 180);
    chk("a3_nb", {31'd0, new_best}, 1);

    attempt(16'd180);
    chk("a4_nb_eq", {31'd0, new_best}, 0);
    rd(2'd3, "a4_att", 4);
    chk("a4_av", {31'd0, avg_valid}, {31'd0, AVG_ON});
    // (250+300+180+180)>>2 = 227
    rd(2'd2, "a4_avg", AVG_ON ? 227 : 0);

    // False start: press while ARMED.
    pulse_arm();
    @(negedge clk) stop = 1'b1;
    repeat (2) @(negedge clk);
    chk("fs1", {31'd0, false_start}, 1);
    stop = 1'b0;
    rd(2'd3, "fs1_att", 4);
    pulse_arm();
    chk("fs_clr_by_arm", {31'd0, false_start}, 0);
    // Press in the same cycle as lights_out.
    @(negedge clk) begin stop = 1'b1; lights_out = 1'b1; end
    @(negedge clk) lights_out = 1'b0;
    repeat (2) @(negedge clk);
    chk("fs2", {31'd0, false_start}, 1);
    stop = 1'b0;
    rd(2'd3, "fs2_att", 4);

    // Averaging window with wrap.
    pulse_clear();
    rd(2'd3, "clr_att", 0);
    chk("clr_av", {31'd0, avg_valid}, 0);
    attempt(16'd100);
    attempt(16'd200);
    attempt(16'd300);
    rd(2'd2, "avg_partial", 0);
    chk("av_partial", {31'd0, avg_valid}, 0);
    attempt(16'd400);
    chk("av_full", {31'd0, avg_valid}, {31'd0, AVG_ON});
    rd(2'd2, "avg_250", AVG_ON ? 250 : 0);
    attempt(16'd500);
    rd(2'd2, "avg_wrap", AVG_ON ? 350 : 0);
    rd(2'd1, "w_best", 100);

    // No response: count saturates while timing.
    @(negedge clk) begin count = 16'hFFFF; arm = 1'b1; end
    @(negedge clk) begin arm = 1'b0; lights_out = 1'b1; end
    @(negedge clk) lights_out = 1'b0;
    repeat (2) @(negedge clk);
    chk("nr", {31'd0, no_response}, 1);
    rd(2'd3, "nr_att", 5);
    rd(2'd0, "nr_last", 500);
    pulse_clear();
    rd(2'd1, "clr_best", 0);
    chk("clr_nr", {31'd0, no_response}, 0);
    chk("clr_fs", {31'd0, false_start}, 0);
    chk("clr_nb", {31'd0, new_best}, 0);

    // Reset mid-timing.
    attempt(16'd123);
    rd(2'd0, "pre_rst_last", 123);
    @(negedge clk) begin count = 16'd77; arm = 1'b1; end
    @(negedge clk) begin arm = 1'b0; lights_out = 1'b1; end
    @(negedge clk) lights_out = 1'b0;
    #2 reset_n = 1'b0;
    #1 chk("mid_rst_disp", {16'd0, disp_value}, 0);
    chk("mid_rst_nb", {31'd0, new_best}, 0);
    @(negedge clk) reset_n = 1'b1;
    @(negedge clk) stop = 1'b1;
    repeat (3) @(negedge clk);
    stop = 1'b0;
    rd(2'd0, "post_rst_last", 0);
    rd(2'd3, "post_rst_att", 0);
    chk("post_rst_nb", {31'd0, new_best}, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/reaction_scoreboard.md
REACTION_SCOREBOARD -- requirements
Module: reaction_scoreboard

Interface
REQ-001 Parameter COUNT_BITS, default 16, width of reaction count and all stored times.
REQ-002 Parameter HIST_LOG2, default 2, log2 of averaging window (2^HIST_LOG2 attempts).
REQ-003 clk  input  1  single system clock; all state on rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 arm  input  1  one-cycle pulse; lights sequence has started.
REQ-006 lights_out  input  1  one-cycle pulse; delay timeout, lights extinguished.
REQ-007 stop  input  1  level, high while the reaction key is pressed (already synchronised).
REQ-008 clear  input  1  one-cycle pulse; wipe all statistics.
REQ-009 count  input  COUNT_BITS  live ms count from the reaction counter.
REQ-010 sel  input  2  display select: 0 last, 1 best, 2 average, 3 attempts.
REQ-011 disp_value  output  COUNT_BITS  selected value, feeds the BCD converter.
REQ-012 false_start  output  1  high from a false start until next arm/clear.
REQ-013 no_response  output  1  high from a count saturation until next arm/clear.
REQ-014 new_best  output  1  high from a record-setting attempt until next arm/clear.
REQ-015 avg_valid  output  1  high once the history window is full.

Function
REQ-016 FSM states IDLE, ARMED, TIMING, RECORD, SHOW; clear has priority over every transition.
REQ-017 IDLE/SHOW: arm -> ARMED; arm clears false_start, no_response, new_best.
REQ-018 ARMED: stop rising edge -> SHOW with false_start=1, nothing recorded; else lights_out -> TIMING.
REQ-019 ARMED, stop edge and lights_out in the same cycle -> false start.
REQ-020 TIMING: stop rising edge -> RECORD; count == 2^COUNT_BITS-1 without stop -> SHOW with no_response=1, nothing recorded.
REQ-021 RECORD (exactly one cycle, then SHOW): last <= count; attempts increments, saturating at all-ones; if first attempt or count < best, best <= count and new_best=1; equal count is not a new best.
REQ-022 Stop rising edge is detected internally from a registered copy of stop; a key held through arm produces no edge.
REQ-023 arm in ARMED/TIMING/RECORD is ignored.
REQ-024 Average = running sum of the last 2^HIST_LOG2 recorded times >> HIST_LOG2; sum width COUNT_BITS+HIST_LOG2, no overflow; oldest entry subtracted when overwritten (circular wrap).
REQ-025 avg_valid rises in the cycle after the 2^HIST_LOG2-th recording; before that, sel=2 shows 0.
REQ-026 disp_value is registered: one-cycle latency from sel or stat change; sel=3 shows attempts zero-extended.
REQ-027 clear (any state): -> IDLE, last/best/sum/attempts/history/flags all 0, avg_valid 0, next cycle.

Reset
REQ-028 reset_n low: state IDLE, all outputs 0, all statistics and history 0, stop edge register 0; asynchronous assertion, synchronous-safe deassertion expected of the source.
REQ-029 Reset mid-TIMING discards the attempt; nothing recorded.

Configuration
REQ-030 Macro SCOREBOARD_AVG_EN defined: history buffer, running sum and average compiled in per REQ-024/025.
REQ-031 Macro undefined: no history storage; sel=2 shows 0; avg_valid tied 0; all other behaviour identical.

Structure
REQ-032 Shared package reaction_pkg holds the FSM state enum and the sel encoding constants (SEL_LAST, SEL_BEST, SEL_AVG, SEL_COUNT).
REQ-033 Sub-module score_history (circular buffer + running sum, write pulse, clear, avg, full) is instantiated only under SCOREBOARD_AVG_EN.

Verification
REQ-034 Reset, then arm, lights_out, stop with count=250 -> sel=0 shows 250, sel=1 shows 250, new_best=1, attempts=1.
REQ-035 Second attempt count=300 then third count=180 -> best 250 then 180; new_best 0 then 1; equal 180 on a fourth attempt -> new_best=0.
REQ-036 arm, stop pressed before lights_out (and separately same cycle as lights_out) -> false_start=1, attempts unchanged.
REQ-037 Four attempts 100, 200, 300, 400 -> avg_valid=1, average 250; fifth 500 -> average 350 (wrap).
REQ-038 In TIMING, count reaches 65535 -> no_response=1, nothing recorded; clear then sel=1 -> 0 and all flags 0.
REQ-039 reset_n asserted mid-TIMING -> all outputs 0 immediately, no recording after release.
